// File: rtl/dff_capture_arbiter_if.sv
// dff_capture_arbiter_if
// Purpose: groups the request/data/grant/capture signals of the shared
//          capture-register arbiter into one bundle.
// Signals:
//   en      - arbitration enable; low blocks new grants only
//   req     - per-requester capture request, level
//   din     - flat data bus, requester i at [i*DW +: DW]
//   gnt     - one-hot ownership of the shared register
//   ack     - one-hot, one-cycle capture-done pulse
//   q       - shared capture register
//   q_valid - one-cycle pulse, q updated
//   busy    - arbiter is in a transaction
// Modports: master drives requests and data, slave is the arbiter.
interface dff_capture_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic                en;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] din;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       q;
  logic                q_valid;
  logic                busy;

  modport master (
    output en, req, din,
    input  gnt, ack, q, q_valid, busy
  );

  modport slave (
    input  en, req, din,
    output gnt, ack, q, q_valid, busy
  );
endinterface

// File: rtl/dff_capture_arbiter.sv
// dff_capture_arbiter
// Purpose: round-robin arbiter that lets one of N_REQ requesters at a time
//          load its data slice into a single shared capture register, then
//          locks out further captures for HOLD cycles.
// Ports:
//   clk - single clock, all state changes on its rising edge
//   rst - asynchronous, active-high reset
//   bus - dff_capture_arbiter_if.slave (en, req, din in; gnt, ack, q,
//         q_valid, busy out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate when en=1 and any req is set
// CAPTURE | winner granted; next edge loads q, pulses ack/q_valid
// HOLD_ST | lockout after capture; cnt counts down to 0, then release
module dff_capture_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  dff_capture_arbiter_if.slave   bus
);

  localparam int              PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW:0]     N_REQ_W  = (PW+1)'(N_REQ);
  localparam logic [PW-1:0]   LAST_IDX = PW'(N_REQ - 1);
  localparam int              HOLD_M1  = (HOLD > 0) ? HOLD - 1 : 0;
  localparam logic [3:0]      CNT_INIT = 4'(HOLD_M1);
  localparam logic [N_REQ-1:0] ONE     = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD_ST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DW-1:0]     q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [3:0]        cnt_q, cnt_d;

  // Rotate requests so bit 0 is the requester at ptr; the first set bit of
  // the rotated vector is the offset of the winner from ptr.
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [PW-1:0]      off;
  logic               found;
  logic [PW:0]        sum;
  logic [PW-1:0]      pick;
  logic [DW-1:0]      cap_data;

  assign req_dbl = {bus.req, bus.req};
  assign req_rot = N_REQ'(req_dbl >> ptr_q);

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        off   = k[PW-1:0];
      end
    end
  end

  // ptr + off, wrapped back into 0..N_REQ-1 (N_REQ need not be a power of 2)
  assign sum  = {1'b0, ptr_q} + {1'b0, off};
  assign pick = (sum >= N_REQ_W) ? PW'(sum - N_REQ_W) : sum[PW-1:0];

  always_comb begin
    cap_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_q == k[PW-1:0]) begin
        cap_data = bus.din[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    q_d       = q_q;
    q_valid_d = 1'b0;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (bus.en && (bus.req != '0)) begin
          win_d   = pick;
          gnt_d   = ONE << pick;
          state_d = CAPTURE;
        end
      end

      // Requests and en are ignored here: once granted, a capture always
      // completes with the data present at the closing edge.
      CAPTURE: begin
        q_d       = cap_data;
        q_valid_d = 1'b1;
        ack_d     = ONE << win_q;
        ptr_d     = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
        if (HOLD == 0) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else begin
          state_d = HOLD_ST;
          cnt_d   = CNT_INIT;
        end
      end

      HOLD_ST: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dff_capture_arbiter.sv
module tb_dff_capture_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          en;
  logic [N-1:0]  req;
  logic [N*DW-1:0] din;

  int n_pass;
  int n_total;

  dff_capture_arbiter_if #(.N_REQ(N), .DW(DW)) bus0 ();
  dff_capture_arbiter_if #(.N_REQ(N), .DW(DW)) bus1 ();

  assign bus0.en  = en;
  assign bus0.req = req;
  assign bus0.din = din;
  assign bus1.en  = en;
  assign bus1.req = req;
  assign bus1.din = din;

  dff_capture_arbiter #(.N_REQ(N), .DW(DW), .HOLD(2)) dut_h2 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  dff_capture_arbiter #(.N_REQ(N), .DW(DW), .HOLD(0)) dut_h0 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: a grant starts a transaction, the data is
  // captured one cycle later, and the owner is released HOLD cycles after
  // the capture. Index 0 models HOLD=2, index 1 models HOLD=0.
  int        holds [2] = '{2, 0};
  bit        m_act   [2];
  int        m_since [2];
  int        m_win   [2];
  int        m_ptr   [2];
  bit        m_cap   [2];
  logic [7:0] m_q    [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_since[d] = 0; m_win[d] = 0;
      m_ptr[d] = 0; m_cap[d] = 0; m_q[d] = 8'h00;
    end
  endtask

  task automatic model_edge(int d);
    bit fnd;
    m_cap[d] = 0;
    if (rst) begin
      m_act[d] = 0; m_since[d] = 0; m_ptr[d] = 0; m_q[d] = 8'h00;
    end else if (m_act[d]) begin
      m_since[d]++;
      if (m_since[d] == 1) begin
        m_cap[d] = 1;
        m_q[d]   = din[m_win[d]*DW +: DW];
        m_ptr[d] = (m_win[d] + 1) % N;
      end
      if (m_since[d] > holds[d]) m_act[d] = 0;
    end else if (en && (req != '0)) begin
      fnd = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr[d] + k) % N;
        if (!fnd && req[idx]) begin
          fnd = 1;
          m_win[d] = idx;
        end
      end
      m_act[d]   = 1;
      m_since[d] = 0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_dut(int d);
    logic [N-1:0] g, a, eg, ea;
    logic [7:0]   qq;
    logic         qv, b;
    if (d == 0) begin
      g = bus0.gnt; a = bus0.ack; qq = bus0.q; qv = bus0.q_valid; b = bus0.busy;
    end else begin
      g = bus1.gnt; a = bus1.ack; qq = bus1.q; qv = bus1.q_valid; b = bus1.busy;
    end
    eg = '0;
    ea = '0;
    if (m_act[d]) eg[m_win[d]] = 1'b1;
    if (m_cap[d]) ea[m_win[d]] = 1'b1;
    chk($sformatf("h%0d_gnt", holds[d]),  32'(g),  32'(eg));
    chk($sformatf("h%0d_ack", holds[d]),  32'(a),  32'(ea));
    chk($sformatf("h%0d_q", holds[d]),    32'(qq), 32'(m_q[d]));
    chk($sformatf("h%0d_qv", holds[d]),   32'(qv), 32'(m_cap[d]));
    chk($sformatf("h%0d_busy", holds[d]), 32'(b),  32'(m_act[d]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  // Reset pulse placed between edges; its effect must be visible at once.
  task automatic async_rst_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    chk("rst_busy_now", 32'(bus0.busy), 32'd0);
    #1 rst = 1'b0;
  endtask

  int           cap_t [$];
  logic [7:0]   cap_v [$];
  logic [N-1:0] ack_seq [$];
  int           cyc;

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; en = 1'b0; req = '0; din = '0;
    model_reset();
    #1;
    chk("por_gnt", 32'(bus0.gnt), 32'd0);
    chk("por_busy", 32'(bus0.busy), 32'd0);
    repeat (2) step();
    rst = 1'b0;

    // Single request from requester 2; req dropped during CAPTURE.
    en = 1'b1; req = 4'b0100; din = 32'h11A5_3344;
    step();
    chk("single_gnt_e0", 32'(bus0.gnt), 32'h4);
    req = 4'b0000;
    step();
    chk("single_q_e1",   32'(bus0.q), 32'hA5);
    chk("single_qv_e1",  32'(bus0.q_valid), 32'd1);
    chk("single_ack_e1", 32'(bus0.ack), 32'h4);
    step();
    chk("single_gnt_e2", 32'(bus0.gnt), 32'h4);
    chk("single_ack_e2", 32'(bus0.ack), 32'h0);
    step();
    chk("single_gnt_e3", 32'(bus0.gnt), 32'h0);
    repeat (2) step();

    // Round-robin with all requests held from a fresh pointer.
    async_rst_pulse();
    req = 4'b1111; din = 32'h4433_2211;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cyc++;
      if (bus0.q_valid) begin cap_t.push_back(cyc); cap_v.push_back(bus0.q); end
    end
    chk("rr_count_ge5", 32'(cap_v.size() >= 5), 32'd1);
    if (cap_v.size() >= 5) begin
      chk("rr_q0", 32'(cap_v[0]), 32'h11);
      chk("rr_q1", 32'(cap_v[1]), 32'h22);
      chk("rr_q2", 32'(cap_v[2]), 32'h33);
      chk("rr_q3", 32'(cap_v[3]), 32'h44);
      chk("rr_q4", 32'(cap_v[4]), 32'h11);
      for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(cap_t[i] - cap_t[i-1]), 32'd4);
    end

    // Wrap: serve 1 then 2 so the pointer sits at 3, then request 0 and 1.
    async_rst_pulse();
    req = 4'b0010; step();
    req = 4'b0000; repeat (4) step();
    req = 4'b0100; step();
    req = 4'b0000; repeat (4) step();
    req = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus0.ack != '0) ack_seq.push_back(bus0.ack);
    end
    chk("wrap_count_ge2", 32'(ack_seq.size() >= 2), 32'd1);
    if (ack_seq.size() >= 2) begin
      chk("wrap_first",  32'(ack_seq[0]), 32'h1);
      chk("wrap_second", 32'(ack_seq[1]), 32'h2);
    end
    req = 4'b0000; repeat (4) step();

    // Enable low blocks grants, then a grant on the first enabled edge.
    en = 1'b0; req = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("en_low_gnt", 32'(bus0.gnt), 32'd0);
    end
    en = 1'b1;
    step();
    chk("en_high_gnt", 32'(bus0.gnt), 32'h8);
    req = 4'b0000; repeat (4) step();

    // Asynchronous reset while in the lockout phase.
    req = 4'b0001; din = 32'h0000_00C3; step();
    req = 4'b0000; step();
    chk("abort_pre_q", 32'(bus0.q), 32'hC3);
    step();
    chk("abort_pre_busy", 32'(bus0.busy), 32'd1);
    async_rst_pulse();
    chk("abort_gnt", 32'(bus0.gnt), 32'd0);
    chk("abort_q",   32'(bus0.q), 32'd0);
    repeat (3) step();

    // Randomised traffic including occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      en  = ($urandom_range(0, 7) != 0);
      din = $urandom;
      step();
      if ($urandom_range(0, 59) == 0) async_rst_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
